// File: rtl/ifetch_queue.sv
// Multi-word instruction fetch into a circular queue feeding decode
// one instruction per cycle, with branch flush of queued/in-flight words.
module ifetch_queue #(
    parameter int              ADDR     = 32,
    parameter int              INST     = 32,
    parameter int              FETCH_W  = 2,
    parameter int              DEPTH    = 8,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    v_i,
    input  logic                    stall_i,
    input  logic                    branch_i,
    input  logic [ADDR-1:0]         baddr_i,
    output logic                    imem_req_o,
    output logic [ADDR-1:0]         imem_addr_o,
    input  logic [FETCH_W*INST-1:0] imem_data_i,
    output logic [INST-1:0]         inst_o,
    output logic [ADDR-1:0]         addr_o,
    output logic                    v_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]     FW_U  = FETCH_W[CW:0];
    localparam logic [CW:0]     DEP_U = DEPTH[CW:0];
    localparam logic [CW-1:0]   FW_C  = FETCH_W[CW-1:0];
    localparam logic [CW-1:0]   ONE_C = 1;
    localparam logic [PW-1:0]   FW_P  = FETCH_W[PW-1:0];
    localparam logic [PW-1:0]   ONE_P = 1;
    localparam logic [ADDR-1:0] FW_A  = FETCH_W[ADDR-1:0];

    logic [INST-1:0] r_inst [DEPTH];
    logic [ADDR-1:0] r_addr [DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;
    logic [ADDR-1:0] r_pc;
    logic [ADDR-1:0] r_start;
    logic            r_infl;

    logic [CW:0]     w_used;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_cnt_nx;

    // Free space counts in-flight words but not same-cycle pops.
    always_comb begin
        w_used   = {1'b0, r_count} + (r_infl ? FW_U : '0);
        w_issue  = ~rst & v_i & ~branch_i & ((w_used + FW_U) <= DEP_U);
        w_push   = r_infl & ~branch_i;
        w_pop    = v_o & ~stall_i;
        w_cnt_nx = r_count + (w_push ? FW_C : '0) - (w_pop ? ONE_C : '0);
    end

    assign v_o         = (r_count != '0) & ~branch_i;
    assign inst_o      = r_inst[r_rd];
    assign addr_o      = r_addr[r_rd];
    assign imem_req_o  = w_issue;
    assign imem_addr_o = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_start <= RESET_PC;
            r_infl  <= 1'b0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= '0;
                r_addr[i] <= '0;
            end
        end else if (branch_i) begin
            r_pc    <= baddr_i;
            r_infl  <= 1'b0;
            r_count <= '0;
            r_rd    <= r_wr;
        end else begin
            r_infl  <= w_issue;
            r_count <= w_cnt_nx;
            if (w_issue) begin
                r_pc    <= r_pc + FW_A;
                r_start <= r_pc;
            end
            if (w_pop) begin
                r_rd <= r_rd + ONE_P;
            end
            if (w_push) begin
                for (int k = 0; k < FETCH_W; k++) begin
                    r_inst[r_wr + PW'(k)] <= imem_data_i[k*INST +: INST];
                    r_addr[r_wr + PW'(k)] <= r_start + ADDR'(k);
                end
                r_wr <= r_wr + FW_P;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-of-addresses reference model plus
// directed scenarios; second instance covers a wrapping reset pc.
module tb_ifetch_queue;
    localparam int FW    = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] baddr_i;
    logic        imem_req_o, imem_req2;
    logic [31:0] imem_addr_o, imem_addr2;
    logic [63:0] imem_data_i, imem_data2;
    logic [31:0] inst_o, addr_o, inst2, addr2;
    logic        v_o, v2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_start;
    logic        m_infl;

    always #5 clk = ~clk;

    ifetch_queue #(.ADDR(32), .INST(32), .FETCH_W(FW), .DEPTH(DEPTH),
                   .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_i(stall_i),
        .branch_i(branch_i), .baddr_i(baddr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_data_i(imem_data_i), .inst_o(inst_o), .addr_o(addr_o),
        .v_o(v_o));

    ifetch_queue #(.ADDR(32), .INST(32), .FETCH_W(FW), .DEPTH(DEPTH),
                   .RESET_PC(32'hFFFF_FFFE)) u_dut2 (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_i(stall_i),
        .branch_i(branch_i), .baddr_i(baddr_i),
        .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
        .imem_data_i(imem_data2), .inst_o(inst2), .addr_o(addr2),
        .v_o(v2));

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    always @(posedge clk) begin
        imem_data_i <= imem_req_o ?
            {memw(imem_addr_o + 32'd1), memw(imem_addr_o)} : 64'hDEAD_BEEF_DEAD_BEEF;
        imem_data2 <= imem_req2 ?
            {memw(imem_addr2 + 32'd1), memw(imem_addr2)} : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    function automatic logic exp_req();
        int used;
        used = mq.size() + (m_infl ? FW : 0);
        return !rst && v_i && !branch_i && (DEPTH - used >= FW);
    endfunction

    function automatic logic exp_vo();
        return (mq.size() != 0) && !branch_i;
    endfunction

    // Advance the reference model with the current inputs, then one clock.
    task automatic tick();
        if (rst) begin
            mq.delete();
            m_pc   = 32'h0;
            m_infl = 1'b0;
        end else if (branch_i) begin
            mq.delete();
            m_pc   = baddr_i;
            m_infl = 1'b0;
        end else begin
            logic iss;
            iss = exp_req();
            if (mq.size() != 0 && !stall_i) void'(mq.pop_front());
            if (m_infl)
                for (int k = 0; k < FW; k++) mq.push_back(m_start + 32'(k));
            m_infl = iss;
            if (iss) begin
                m_start = m_pc;
                m_pc    = m_pc + 32'(FW);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; v_i = 1'b1; stall_i = 1'b0;
        branch_i = 1'b1; baddr_i = 32'h55;
        tick();
        tick();
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got %b want 0", imem_req_o);
        end
        rst = 1'b0; branch_i = 1'b0;
        #1;
        checks++;
        if (v_o !== 1'b0 || addr_o !== 32'h0 || inst_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_out got v=%b a=%h i=%h want 0 0 0", v_o, addr_o, inst_o);
        end
        checks++;
        if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pc got %h/%b want 0/1", imem_addr_o, imem_req_o);
        end
        checks++;
        if (imem_addr2 !== 32'hFFFF_FFFE || v2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_pc2 got %h/%b want fffffffe/0", imem_addr2, v2);
        end
    endtask

    task automatic test_stream();
        int first_req = -1;
        int first_vo  = -1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (imem_req_o && first_req < 0) first_req = cyc;
            if (v_o && first_vo < 0) first_vo = cyc;
            checks++;
            if (imem_req_o !== exp_req() || imem_addr_o !== m_pc) begin
                errors++;
                $display("FAIL stream_req c%0d got %b/%h want %b/%h",
                         cyc, imem_req_o, imem_addr_o, exp_req(), m_pc);
            end
            checks++;
            if (v_o !== exp_vo()) begin
                errors++;
                $display("FAIL stream_vo c%0d got %b want %b", cyc, v_o, exp_vo());
            end
            if (exp_vo()) begin
                checks++;
                if (addr_o !== mq[0] || inst_o !== memw(mq[0])) begin
                    errors++;
                    $display("FAIL stream_head c%0d got %h/%h want %h/%h",
                             cyc, addr_o, inst_o, mq[0], memw(mq[0]));
                end
            end
            tick();
        end
        checks++;
        if (first_vo - first_req != 2) begin
            errors++;
            $display("FAIL stream_latency got %0d want 2", first_vo - first_req);
        end
    endtask

    task automatic test_stall();
        logic [31:0] head;
        stall_i = 1'b1;
        head = mq[0];
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (v_o !== 1'b1 || addr_o !== head || inst_o !== memw(head)) begin
                errors++;
                $display("FAIL stall_hold c%0d got %b/%h want 1/%h", cyc, v_o, addr_o, head);
            end
            checks++;
            if (imem_req_o !== exp_req()) begin
                errors++;
                $display("FAIL stall_req c%0d got %b want %b", cyc, imem_req_o, exp_req());
            end
            tick();
        end
        #1;
        checks++;
        if (imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_full_req got %b want 0", imem_req_o);
        end
        stall_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (v_o !== exp_vo() || (exp_vo() && addr_o !== mq[0])) begin
                errors++;
                $display("FAIL stall_resume c%0d got %b/%h want %b/%h",
                         cyc, v_o, addr_o, exp_vo(), exp_vo() ? mq[0] : 32'h0);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [31:0] first;
        logic        got;
        got = 1'b0;
        first = 32'h0;
        branch_i = 1'b1; baddr_i = 32'h2;
        #1;
        checks++;
        if (v_o !== 1'b0 || imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL br_cycle got v=%b req=%b want 0 0", v_o, imem_req_o);
        end
        tick();
        branch_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c < 2) begin
                checks++;
                if (v_o !== 1'b0) begin
                    errors++;
                    $display("FAIL br_bubble c%0d got %b want 0", c, v_o);
                end
            end
            if (c == 0) begin
                checks++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2) begin
                    errors++;
                    $display("FAIL br_issue got %b/%h want 1/2", imem_req_o, imem_addr_o);
                end
            end
            if (v_o && !got) begin
                got = 1'b1;
                first = addr_o;
            end
            checks++;
            if (v_o !== exp_vo() || (exp_vo() && addr_o !== mq[0])) begin
                errors++;
                $display("FAIL br_stream c%0d got %b/%h want %b/%h",
                         cyc, v_o, addr_o, exp_vo(), exp_vo() ? mq[0] : 32'h0);
            end
            tick();
        end
        checks++;
        if (!got || first !== 32'h2) begin
            errors++;
            $display("FAIL br_first got %h want 2", first);
        end
    endtask

    task automatic test_branch_full();
        int n;
        stall_i = 1'b1;
        repeat (12) tick();
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || v_o !== 1'b1) begin
            errors++;
            $display("FAIL bf_full got req=%b v=%b want 0 1", imem_req_o, v_o);
        end
        branch_i = 1'b1; baddr_i = 32'h5;
        tick();
        branch_i = 1'b0; stall_i = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            #1;
            if (v_o) begin
                checks++;
                if (addr_o !== 32'(5 + n) || inst_o !== 32'h1000_0005 + 32'(n)) begin
                    errors++;
                    $display("FAIL bf_out n%0d got %h/%h want %h", n, addr_o, inst_o, 32'(5 + n));
                end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bf_timeout got %0d pops want 4", n);
        end
    endtask

    task automatic test_wrap_vi();
        logic [31:0] exp2;
        int n;
        rst = 1'b1; branch_i = 1'b0; stall_i = 1'b0; v_i = 1'b1;
        tick();
        rst = 1'b0;
        exp2 = 32'hFFFF_FFFE;
        n = 0;
        for (int c = 0; c < 28; c++) begin
            v_i = !(c >= 8 && c < 12);
            #1;
            if (v2) begin
                checks++;
                if (addr2 !== exp2 || inst2 !== memw(exp2)) begin
                    errors++;
                    $display("FAIL wrap_out c%0d got %h/%h want %h/%h",
                             c, addr2, inst2, exp2, memw(exp2));
                end
                exp2++;
                n++;
            end
            checks++;
            if (imem_req2 !== exp_req() || imem_addr2 !== m_pc - 32'd2) begin
                errors++;
                $display("FAIL wrap_req c%0d got %b/%h want %b/%h",
                         c, imem_req2, imem_addr2, exp_req(), m_pc - 32'd2);
            end
            checks++;
            if (v_o !== exp_vo() || (exp_vo() && addr_o !== mq[0])) begin
                errors++;
                $display("FAIL vi_main c%0d got %b/%h want %b", c, v_o, addr_o, exp_vo());
            end
            tick();
        end
        checks++;
        if (n < 16) begin
            errors++;
            $display("FAIL wrap_count got %0d want >=16", n);
        end
    endtask

    task automatic test_reset_branch();
        logic got;
        got = 1'b0;
        v_i = 1'b1; stall_i = 1'b0;
        repeat (6) tick();
        rst = 1'b1; branch_i = 1'b1; baddr_i = 32'h9;
        tick();
        rst = 1'b0; branch_i = 1'b0;
        #1;
        checks++;
        if (v_o !== 1'b0 || imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rb_state got v=%b pc=%h req=%b want 0 0 1", v_o, imem_addr_o, imem_req_o);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            if (v_o && !got) begin
                got = 1'b1;
                checks++;
                if (addr_o !== 32'h0) begin
                    errors++;
                    $display("FAIL rb_first got %h want 0", addr_o);
                end
            end
            tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rb_timeout got no pop want addr 0");
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            v_i      = ($urandom_range(0, 9) != 0);
            stall_i  = ($urandom_range(0, 3) == 0);
            branch_i = ($urandom_range(0, 19) == 0);
            baddr_i  = ($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFF_FFFD;
            #1;
            checks++;
            if (imem_req_o !== exp_req() || imem_addr_o !== m_pc) begin
                errors++;
                $display("FAIL rnd_req c%0d got %b/%h want %b/%h",
                         cyc, imem_req_o, imem_addr_o, exp_req(), m_pc);
            end
            checks++;
            if (v_o !== exp_vo()) begin
                errors++;
                $display("FAIL rnd_vo c%0d got %b want %b", cyc, v_o, exp_vo());
            end
            if (exp_vo()) begin
                checks++;
                if (addr_o !== mq[0] || inst_o !== memw(mq[0])) begin
                    errors++;
                    $display("FAIL rnd_head c%0d got %h/%h want %h/%h",
                             cyc, addr_o, inst_o, mq[0], memw(mq[0]));
                end
            end
            tick();
        end
        branch_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; v_i = 1'b0; stall_i = 1'b0;
        branch_i = 1'b0; baddr_i = 32'h0;
        m_pc = 32'h0; m_start = 32'h0; m_infl = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_branch_full();
        test_wrap_vi();
        test_reset_branch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised successor to the single-word ifetch stage: fetches FETCH_W consecutive instruction words per request into a DEPTH-entry instruction queue.
- Delivers one instruction per cycle to decode with its word address.
- Handles stall back-pressure, fetch enable and branch redirect with flush of queued and in-flight instructions.
- Sits between instruction memory (synchronous read, fixed 1-cycle latency) and decode.

Parameters:
- ADDR, 32, word-address width (addresses are word-granular, not byte).
- INST, 32, instruction width.
- FETCH_W, 2, words fetched per request; 1..4.
- DEPTH, 8, queue entries; power of two, >= 2*FETCH_W.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- v_i  in  1  fetch enable; 0 blocks new requests, queue still drains.
- stall_i  in  1  decode stall; head not consumed while 1.
- branch_i  in  1  redirect request, one-cycle pulse.
- baddr_i  in  ADDR  redirect target, valid with branch_i.
- imem_req_o  out  1  memory read request this cycle.
- imem_addr_o  out  ADDR  request start address (pc).
- imem_data_i  in  FETCH_W*INST  words for the request issued the previous cycle; lane k = [k*INST +: INST] = word at req_addr+k.
- inst_o  out  INST  head instruction.
- addr_o  out  ADDR  word address of inst_o.
- v_o  out  1  inst_o/addr_o valid.

Behaviour:
- Reset (sync, highest priority, overrides branch_i): pc=RESET_PC; queue empty (count=0, rd/wr pointers 0); inflight=0; v_o=0; imem_req_o=0; inst_o=0; addr_o=0.
- State: pc, inflight flag plus inflight start address, circular queue with rd/wr pointers and count (clog2(DEPTH+1) bits).
- Issue condition: v_i & ~branch_i & (DEPTH - count - (inflight ? FETCH_W : 0) >= FETCH_W). Uses registered count; same-cycle pops are not credited.
- On issue: imem_req_o=1, imem_addr_o=pc, pc<=pc+FETCH_W modulo 2^ADDR, inflight<=1, record start address.
- When no issue: imem_req_o=0, imem_addr_o=pc, inflight<=0.
- Response: cycle after issue, if inflight & ~branch_i, push all FETCH_W lanes in lane order (lane 0 nearest head), address start+k modulo 2^ADDR. Never partial.
- Output is combinational from the head register: v_o = (count != 0) & ~branch_i.
- Pop when v_o & ~stall_i.
- Push and pop in the same cycle: count += FETCH_W-1.
- Latency: issue at cycle N, data on imem_data_i at N+1, v_o high at N+2 (no bypass).
- Branch (branch_i=1 in cycle N):
  - No pop, no issue, no push; any response arriving in N is discarded.
  - Queue flushed (count=0) at end of N; pc<=baddr_i.
  - Issue of baddr_i at N+1 if v_i; first redirected v_o at N+3.
  - baddr_i may be any word address; no alignment.
- Full queue with stall_i=1: issue stops; v_o, inst_o, addr_o hold the head unchanged; no overflow, no loss.
- v_i=0: no new requests; an in-flight response is still pushed; pc unchanged.
- Empty queue: v_o=0; inst_o/addr_o don't-care (hold last head storage).
- Ordering: addr_o strictly increments by 1 (mod 2^ADDR) between consecutive pops unless a branch intervenes. No duplicate or skipped word.

Test Plan:
- Memory model: mem[a]=32'h1000_0000+a. FETCH_W=2, DEPTH=8, RESET_PC=0, v_i=1, stall_i=0. Release reset -> imem_addr_o 0,2,4,... every cycle; v_o first high 2 cycles after first request. Pops give addr_o 0,1,2,3,... with inst_o 10000000,10000001,... Steady state stays at one per cycle, gap-free.
- Stall stall_i=1 from cycle 5 -> count reaches 8; imem_req_o drops once free<2; head frozen. Release -> stream resumes in order, no gap or duplicate.
- branch_i=1, baddr_i=2 while stream at addr_o~6 -> v_o=0 in branch cycle and the next 2 cycles. Next pops 2,3,4,...; the in-flight pair is never output.
- Branch while full and stalled, baddr_i=5 -> queue empties. After release, outputs 5,6,7,8 with inst 10000005...
- RESET_PC=32'hFFFF_FFFE -> addr_o FFFFFFFE, FFFFFFFF, 00000000, 00000001. Then toggle v_i=0 for 4 cycles: queue drains, imem_req_o=0, resume continues at next pc.
- rst=1 asserted mid-stream together with branch_i=1 -> next cycle v_o=0, count=0, imem_addr_o=RESET_PC. Branch ignored; stream restarts at RESET_PC.
